// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// Parametrised modulo-MODULUS up/down counter. Generalises the fixed 3-bit
// Moore/Mealy counter examples. It adds a count enable, a synchronous clamped
// load, a choice of wrap or saturate at the range ends, a Mealy terminal-count
// pulse and a sticky overflow flag.
//
// Parameters
//   WIDTH    bit width of state/out/load_val
//   MODULUS  number of count states; the count stays in 0..MODULUS-1
//   WRAP     1: wrap around at either end, 0: hold (saturate) at either end
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-high reset
//   en          in   1      count enable
//   mode        in   1      1 = count up, 0 = count down
//   load        in   1      synchronous load request (has priority over en)
//   load_val    in   WIDTH  value to load, clamped to MODULUS-1
//   clr_ovf     in   1      synchronous clear of ovf
//   out         out  WIDTH  registered count (Moore output, equals state)
//   state       out  WIDTH  current state register
//   next_state  out  WIDTH  value state takes at the next edge (combinational)
//   tc          out  1      terminal count, combinational (Mealy)
//   ovf         out  1      sticky boundary-hit flag, registered
// -----------------------------------------------------------------------------
module param_updown_counter #(
   parameter int unsigned WIDTH   = 3,
   parameter int unsigned MODULUS = 8,
   parameter bit          WRAP    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] next_state,
   output logic             tc,
   output logic             ovf
);

   // The modulus must give at least two states and fit in WIDTH bits.
   if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_params
      $error("param_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;
   logic [WIDTH-1:0] load_clamped;
   logic             at_max;
   logic             at_min;
   logic             tc_c;
   logic             ovf_q;

   assign at_max = (state_q == MAX_VAL);
   assign at_min = (state_q == '0);

   // An out-of-range load value is clamped to the top of the range.
   // load_val < MODULUS is the same test as load_val <= MAX_VAL.
   assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

   // tc fires whenever an enabled, unloaded step would cross a range end.
   // It fires in both wrap and saturate modes.
   assign tc_c = en & ~load & ((mode & at_max) | (~mode & at_min));

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = load_clamped;
      end else if (en) begin
         if (mode) begin
            if (at_max) state_d = WRAP ? '0 : MAX_VAL;
            else        state_d = state_q + ONE;
         end else begin
            if (at_min) state_d = WRAP ? MAX_VAL : '0;
            else        state_d = state_q - ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= '0;
      else     state_q <= state_d;
   end

   // A boundary hit sets ovf, and setting wins over a clear on the same edge.
   // A load leaves ovf unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          ovf_q <= 1'b0;
      else if (tc_c)    ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
   end

   assign out        = state_q;
   assign state      = state_q;
   assign next_state = state_d;
   assign tc         = tc_c;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

   localparam int M = 6;

   logic       clk;
   logic       rst;
   logic       en;
   logic       mode;
   logic       load;
   logic [2:0] load_val;
   logic       clr_ovf;

   // Index 0: the WRAP=1 instance. Index 1: the WRAP=0 (saturating) instance.
   logic [2:0] out_w, state_w, next_w, out_s, state_s, next_s;
   logic       tc_w, ovf_w, tc_s, ovf_s;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   int m_cnt [2];
   bit m_ovf [2];
   bit pre_tc_w;

   param_updown_counter #(.WIDTH(3), .MODULUS(M), .WRAP(1'b1)) dut_wrap (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf), .out(out_w), .state(state_w),
      .next_state(next_w), .tc(tc_w), .ovf(ovf_w)
   );

   param_updown_counter #(.WIDTH(3), .MODULUS(M), .WRAP(1'b0)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf), .out(out_s), .state(state_s),
      .next_state(next_s), .tc(tc_s), .ovf(ovf_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // The model is written from the counting rules: arithmetic modulo M, or
   // clamping with min/max when the instance saturates.
   function automatic int model_next(input int s, input bit wrap);
      int lv;
      lv = int'(load_val);
      if (load)   return (lv < M) ? lv : M - 1;
      if (!en)    return s;
      if (mode)   return wrap ? (s + 1) % M : ((s + 1 > M - 1) ? M - 1 : s + 1);
      return wrap ? (s + M - 1) % M : ((s - 1 < 0) ? 0 : s - 1);
   endfunction

   function automatic bit model_tc(input int s);
      return en && !load && ((mode && s == M - 1) || (!mode && s == 0));
   endfunction

   task automatic check_regs(input string tag);
      chk({tag, " out_wrap"},   int'(out_w),   m_cnt[0]);
      chk({tag, " state_wrap"}, int'(state_w), m_cnt[0]);
      chk({tag, " ovf_wrap"},   int'(ovf_w),   int'(m_ovf[0]));
      chk({tag, " out_sat"},    int'(out_s),   m_cnt[1]);
      chk({tag, " state_sat"},  int'(state_s), m_cnt[1]);
      chk({tag, " ovf_sat"},    int'(ovf_s),   int'(m_ovf[1]));
   endtask

   // Apply the inputs away from the clock edge and check the combinational
   // outputs. Then take one rising edge and check the registered outputs.
   task automatic step(input bit e, input bit m, input bit l, input int lv,
                       input bit c, input string tag);
      bit t0, t1;
      en = e; mode = m; load = l; load_val = 3'(lv); clr_ovf = c;
      #1;
      chk({tag, " next_wrap"}, int'(next_w), model_next(m_cnt[0], 1'b1));
      chk({tag, " next_sat"},  int'(next_s), model_next(m_cnt[1], 1'b0));
      chk({tag, " tc_wrap"},   int'(tc_w),   int'(model_tc(m_cnt[0])));
      chk({tag, " tc_sat"},    int'(tc_s),   int'(model_tc(m_cnt[1])));
      pre_tc_w = tc_w;
      @(posedge clk);
      t0 = model_tc(m_cnt[0]);
      t1 = model_tc(m_cnt[1]);
      m_ovf[0] = t0 ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf[0]);
      m_ovf[1] = t1 ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf[1]);
      m_cnt[0] = model_next(m_cnt[0], 1'b1);
      m_cnt[1] = model_next(m_cnt[1], 1'b0);
      #1;
      check_regs(tag);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      m_cnt[0] = 0; m_cnt[1] = 0; m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
      check_regs("reset");
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      bit e; bit m; bit l; int lv; bit c;
      bit exp_tc; int exp_out; bit exp_ovf;
   } vec_t;

   vec_t vecs [16];

   initial begin
      // Expected values for the wrapping instance.
      // exp_tc is sampled before the edge; exp_out and exp_ovf after it.
      //          e  m  l lv c  tc out ovf
      vecs[0]  = '{1, 1, 0, 0, 0, 0, 1, 0};
      vecs[1]  = '{1, 1, 0, 0, 0, 0, 2, 0};
      vecs[2]  = '{1, 1, 0, 0, 0, 0, 3, 0};
      vecs[3]  = '{1, 1, 0, 0, 0, 0, 4, 0};
      vecs[4]  = '{1, 1, 0, 0, 0, 0, 5, 0};
      vecs[5]  = '{1, 1, 0, 0, 0, 1, 0, 1};
      vecs[6]  = '{1, 1, 0, 0, 0, 0, 1, 1};
      vecs[7]  = '{1, 1, 0, 0, 0, 0, 2, 1};
      vecs[8]  = '{0, 1, 1, 0, 0, 0, 0, 1};
      vecs[9]  = '{1, 0, 0, 0, 0, 1, 5, 1};
      vecs[10] = '{1, 0, 0, 0, 0, 0, 4, 1};
      vecs[11] = '{1, 0, 0, 0, 0, 0, 3, 1};
      vecs[12] = '{0, 0, 1, 7, 0, 0, 5, 1};
      vecs[13] = '{1, 1, 1, 2, 0, 0, 2, 1};
      vecs[14] = '{0, 0, 0, 0, 1, 0, 2, 0};
      vecs[15] = '{0, 0, 0, 0, 0, 0, 2, 0};

      rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0; clr_ovf = 1'b0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_regs("reset_init");
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         step(vecs[i].e, vecs[i].m, vecs[i].l, vecs[i].lv, vecs[i].c, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d tbl_tc", i),  int'(pre_tc_w), int'(vecs[i].exp_tc));
         chk($sformatf("vec%0d tbl_out", i), int'(out_w),    vecs[i].exp_out);
         chk($sformatf("vec%0d tbl_ovf", i), int'(ovf_w),    int'(vecs[i].exp_ovf));
      end

      // Saturating instance counts up from 4 and holds at 5, with tc held high.
      step(0, 0, 1, 4, 0, "sat_load4");
      chk("sat_load4 out", int'(out_s), 4);
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 0, 0, 0, $sformatf("sat_up%0d", i));
         chk($sformatf("sat_up%0d out", i), int'(out_s), 5);
         #1;
         chk($sformatf("sat_up%0d tc", i), int'(tc_s), 1);
      end
      step(1, 0, 0, 0, 0, "sat_down");
      chk("sat_down out", int'(out_s), 4);

      // Asynchronous reset between edges while out=3 and ovf=1.
      step(0, 0, 1, 0, 0, "ar_load0");
      step(1, 0, 0, 0, 0, "ar_under");
      step(0, 0, 1, 3, 0, "ar_load3");
      chk("ar_pre out", int'(out_w), 3);
      chk("ar_pre ovf", int'(ovf_w), 1);
      #2;
      rst = 1'b1;
      #1;
      m_cnt[0] = 0; m_cnt[1] = 0; m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
      chk("ar_mid out", int'(out_w), 0);
      chk("ar_mid ovf", int'(ovf_w), 0);
      #1;
      rst = 1'b0;
      step(1, 1, 0, 0, 0, "ar_resume");
      chk("ar_resume out", int'(out_w), 1);

      // A set and a clear of ovf on the same edge: the set wins.
      step(0, 0, 1, 5, 0, "ovf_load5a");
      step(1, 1, 0, 0, 0, "ovf_set");
      chk("ovf_set ovf", int'(ovf_w), 1);
      step(0, 0, 1, 5, 0, "ovf_load5b");
      step(1, 1, 0, 0, 1, "ovf_setclr");
      chk("ovf_setclr ovf", int'(ovf_w), 1);
      step(0, 1, 0, 0, 1, "ovf_clr");
      chk("ovf_clr ovf", int'(ovf_w), 0);

      // Random stimulus checked against the model, with occasional resets.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) do_reset();
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 5) == 0), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
